// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: operands are captured on start and summed LSB-first,
// DIGIT bits per clock, through one carry register.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_badParams
      $error("serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             carryOut_q, carryOut_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] digSum;
  logic             digCarry;
  logic             topCarryIn;
  logic             ripple;
  logic [WIDTH-1:0] partialNext;

  // Ripple over the current digit; the carry entering its top bit feeds overflow detection.
  always_comb begin
    ripple     = carry_q;
    digSum     = '0;
    topCarryIn = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) topCarryIn = ripple;
      digSum[i] = aShift_q[i] ^ bShift_q[i] ^ ripple;
      ripple    = (aShift_q[i] & bShift_q[i]) | (ripple & (aShift_q[i] ^ bShift_q[i]));
    end
    digCarry    = ripple;
    partialNext = (partial_q >> DIGIT) | (WIDTH'(digSum) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    partial_d  = partial_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1, with the +1 supplied by the initial carry.
          aShift_d  = in_a;
          bShift_d  = sub ? ~in_b : in_b;
          carry_d   = sub;
          cnt_d     = '0;
          partial_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        aShift_d  = aShift_q >> DIGIT;
        bShift_d  = bShift_q >> DIGIT;
        partial_d = partialNext;
        carry_d   = digCarry;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
          sum_d      = partialNext;
          carryOut_d = digCarry;
          ovf_d      = topCarryIn ^ digCarry;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      partial_q  <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      partial_q  <= partial_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum_out   = sum_q;
  assign carry_out = carryOut_q;
  assign overflow  = ovf_q;

endmodule
